// File: rtl/hub75_shifter.sv
// HUB75 bit-plane shift engine: fetches one physical row from the frame buffer,
// serialises the selected bit plane with the shift clock, then latches while blanked.
module hub75_shifter #(
   parameter int hpixel_p   = 64,
   parameter int vpixel_p   = 64,
   parameter int bpp_p      = 8,
   parameter int segments_p = 2
) (
   input  logic                                            clk,
   input  logic                                            rst_n,
   input  logic                                            i_shift_en,
   input  logic                                            i_start,
   input  logic [$clog2(vpixel_p/segments_p)-1:0]          i_row,
   input  logic [$clog2(bpp_p)-1:0]                        i_pix_bit,
   input  logic                                            i_blank,
   output logic                                            o_rd_en,
   output logic [$clog2(hpixel_p*vpixel_p/segments_p)-1:0] o_rd_addr,
   input  logic [segments_p*3*bpp_p-1:0]                   i_rd_data,
   output logic [segments_p*3-1:0]                         o_rgb,
   output logic                                            o_clk,
   output logic                                            o_lat,
   output logic                                            o_busy,
   output logic                                            o_done
);

   localparam int RowW = $clog2(vpixel_p/segments_p);
   localparam int ColW = $clog2(hpixel_p);
   localparam int BitW = $clog2(bpp_p);
   localparam int RgbW = segments_p*3;
   localparam int AddrW = $clog2(hpixel_p*vpixel_p/segments_p);
   localparam logic [ColW-1:0] LastCol = ColW'(hpixel_p-1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_LATCH,
      ST_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [RowW-1:0]   row_q, row_d;
   logic [BitW-1:0]   bit_q, bit_d;
   logic [ColW-1:0]   col_q, col_d;
   logic              rd_en_q, rd_en_d;
   logic [AddrW-1:0]  rd_addr_q, rd_addr_d;
   logic [RgbW-1:0]   rgb_q, rgb_d;
   logic              clk_q, clk_d;
   logic              lat_q, lat_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [BitW-1:0]   start_bit;
   logic [ColW-1:0]   col_inc;
   logic [RgbW-1:0]   plane_bits;

   assign col_inc = col_q + ColW'(1);

   always_comb begin
      start_bit = i_pix_bit;
      if (int'(i_pix_bit) >= bpp_p) begin
         start_bit = BitW'(bpp_p - 1);
      end
   end

   // Read data is consumed straight off the port in the one cycle it is valid;
   // the o_rgb register itself serves as the column hold stage.
   for (genvar s = 0; s < segments_p; s++) begin : g_seg
      logic [bpp_p-1:0] r_w, g_w, b_w;
      assign r_w = i_rd_data[s*3*bpp_p + 2*bpp_p +: bpp_p];
      assign g_w = i_rd_data[s*3*bpp_p +   bpp_p +: bpp_p];
      assign b_w = i_rd_data[s*3*bpp_p           +: bpp_p];
      assign plane_bits[s*3+2] = r_w[bit_q];
      assign plane_bits[s*3+1] = g_w[bit_q];
      assign plane_bits[s*3]   = b_w[bit_q];
   end

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      bit_d     = bit_q;
      col_d     = col_q;
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      rgb_d     = rgb_q;
      clk_d     = 1'b0;
      lat_d     = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      if (!i_shift_en) begin
         state_d = ST_IDLE;
         rgb_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  state_d   = ST_FETCH;
                  row_d     = i_row;
                  bit_d     = start_bit;
                  col_d     = '0;
                  rd_en_d   = 1'b1;
                  rd_addr_d = {i_row, {ColW{1'b0}}};
                  busy_d    = 1'b1;
               end
            end
            ST_FETCH: begin
               busy_d  = 1'b1;
               state_d = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
               busy_d  = 1'b1;
               rgb_d   = plane_bits;
               state_d = ST_SHIFT_HI;
               if (col_q != LastCol) begin
                  rd_en_d   = 1'b1;
                  rd_addr_d = {row_q, col_inc};
               end
            end
            ST_SHIFT_HI: begin
               busy_d = 1'b1;
               clk_d  = 1'b1;
               if (col_q == LastCol) begin
                  state_d = ST_LATCH;
               end else begin
                  col_d   = col_inc;
                  state_d = ST_SHIFT_LO;
               end
            end
            ST_LATCH: begin
               busy_d = 1'b1;
               if (i_blank) begin
                  lat_d   = 1'b1;
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         row_q     <= '0;
         bit_q     <= '0;
         col_q     <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         rgb_q     <= '0;
         clk_q     <= 1'b0;
         lat_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         bit_q     <= bit_d;
         col_q     <= col_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         rgb_q     <= rgb_d;
         clk_q     <= clk_d;
         lat_q     <= lat_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign o_rd_en   = rd_en_q;
   assign o_rd_addr = rd_addr_q;
   assign o_rgb     = rgb_q;
   assign o_clk     = clk_q;
   assign o_lat     = lat_q;
   assign o_busy    = busy_q;
   assign o_done    = done_q;

endmodule
